// File: rtl/vending_controller_multi.sv
`default_nettype none
// ============================================================================
// Module   : vending_controller_multi
// Purpose  : Multi-item vending controller. Accepts valued coins into a
//            saturating credit register, serves N_ITEMS items with individual
//            prices and stock counters, hands the chosen item to a dispenser
//            over valid/ready, then pays out change or a refund one unit per
//            cycle.
// Ports    : clk_i, reset_i (async, active-high)
//            coin_valid_i/coin_val_i   : coin acceptor input
//            sel_valid_i/sel_item_i    : keypad selection
//            cancel_i                  : refund request
//            price_table_i             : static flattened price list
//            refill_i/refill_item_i    : restock request
//            vend_ready_i/vend_valid_o/vend_item_o : dispenser handshake
//            change_o                  : one unit paid out per high cycle
//            credit_o                  : current credit
//            coin_reject_o, sold_out_o, need_more_o : one-cycle status pulses
//            busy_o                    : high while vending or paying out
// Revision : 1.0 - initial release
// ============================================================================
module vending_controller_multi #(
    parameter int N_ITEMS    = 4,
    parameter int SEL_W      = 2,
    parameter int COIN_W     = 2,
    parameter int CREDIT_W   = 4,
    parameter int MAX_CREDIT = 9,
    parameter int STOCK_W    = 3,
    parameter int STOCK_INIT = 2
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         coin_valid_i,
    input  logic [COIN_W-1:0]            coin_val_i,
    input  logic                         sel_valid_i,
    input  logic [SEL_W-1:0]             sel_item_i,
    input  logic                         cancel_i,
    input  logic [N_ITEMS*CREDIT_W-1:0]  price_table_i,
    input  logic                         refill_i,
    input  logic [SEL_W-1:0]             refill_item_i,
    input  logic                         vend_ready_i,
    output logic                         vend_valid_o,
    output logic [SEL_W-1:0]             vend_item_o,
    output logic                         change_o,
    output logic [CREDIT_W-1:0]          credit_o,
    output logic                         coin_reject_o,
    output logic                         sold_out_o,
    output logic                         need_more_o,
    output logic                         busy_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_VEND    = 3'd2,
        S_CHANGE  = 3'd3,
        S_REFUND  = 3'd4
    } state_t;

    localparam logic [CREDIT_W:0]  C_MAX_SUM    = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [STOCK_W-1:0] C_STOCK_INIT = STOCK_W'(STOCK_INIT);

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic [SEL_W-1:0]      vend_item_q, vend_item_d;
    logic [STOCK_W-1:0]    stock_q [N_ITEMS];
    logic [STOCK_W-1:0]    stock_d [N_ITEMS];
    logic                  vend_valid_q, vend_valid_d;
    logic                  change_q, change_d;
    logic                  coin_reject_q, coin_reject_d;
    logic                  sold_out_q, sold_out_d;
    logic                  need_more_q, need_more_d;
    logic                  busy_q, busy_d;

    logic                  coin_present;
    logic [CREDIT_W:0]     coin_sum;
    logic                  sel_in_range;
    logic [STOCK_W-1:0]    sel_stock;
    logic [CREDIT_W-1:0]   sel_price;
    logic [CREDIT_W-1:0]   vend_price;
    logic [CREDIT_W-1:0]   vend_remain;
    logic                  vend_take;

    // A zero-valued coin is treated as no coin at all (never rejected).
    assign coin_present = coin_valid_i && (coin_val_i != '0);
    // One extra bit so an over-limit sum is detected instead of wrapping.
    assign coin_sum     = {1'b0, credit_q} + (CREDIT_W+1)'(coin_val_i);

    // Decoded lookups by loop compare: an out-of-range selection simply
    // matches no item and is reported as sold out.
    always_comb begin
        sel_in_range = 1'b0;
        sel_stock    = '0;
        sel_price    = '0;
        vend_price   = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (sel_item_i == SEL_W'(i)) begin
                sel_in_range = 1'b1;
                sel_stock    = stock_q[i];
                sel_price    = price_table_i[i*CREDIT_W +: CREDIT_W];
            end
            if (vend_item_q == SEL_W'(i)) begin
                vend_price = price_table_i[i*CREDIT_W +: CREDIT_W];
            end
        end
    end

    assign vend_remain = credit_q - vend_price;

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        vend_item_d   = vend_item_q;
        coin_reject_d = 1'b0;
        sold_out_d    = 1'b0;
        need_more_d   = 1'b0;
        vend_take     = 1'b0;

        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (cancel_i) begin
                    coin_reject_d = coin_present;
                    if (state_q == S_COLLECT) begin
                        state_d = S_REFUND;
                    end
                end else if (sel_valid_i) begin
                    coin_reject_d = coin_present;
                    if (state_q == S_COLLECT) begin
                        if (!sel_in_range || (sel_stock == '0)) begin
                            sold_out_d = 1'b1;
                        end else if (credit_q < sel_price) begin
                            need_more_d = 1'b1;
                        end else begin
                            state_d     = S_VEND;
                            vend_item_d = sel_item_i;
                        end
                    end
                end else if (coin_present) begin
                    if (coin_sum <= C_MAX_SUM) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = S_COLLECT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            S_VEND: begin
                coin_reject_d = coin_present;
                if (vend_valid_q && vend_ready_i) begin
                    vend_take = 1'b1;
                    credit_d  = vend_remain;
                    state_d   = (vend_remain != '0) ? S_CHANGE : S_IDLE;
                end
            end
            S_CHANGE, S_REFUND: begin
                coin_reject_d = coin_present;
                // The pulse for the last unit is already on the output, so
                // leave as soon as the final unit is being counted off.
                if (credit_q <= CREDIT_W'(1)) begin
                    credit_d = '0;
                    state_d  = S_IDLE;
                end else begin
                    credit_d = credit_q - CREDIT_W'(1);
                end
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase

        vend_valid_d = (state_d == S_VEND);
        change_d     = (state_d == S_CHANGE) || (state_d == S_REFUND);
        busy_d       = (state_d == S_VEND) || change_d;
    end

    // Refill is applied after the vend decrement so it wins on a collision.
    always_comb begin
        stock_d = stock_q;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (vend_take && (vend_item_q == SEL_W'(i)) && (stock_q[i] != '0)) begin
                stock_d[i] = stock_q[i] - STOCK_W'(1);
            end
            if (refill_i && (refill_item_i == SEL_W'(i))) begin
                stock_d[i] = C_STOCK_INIT;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            vend_item_q   <= '0;
            vend_valid_q  <= 1'b0;
            change_q      <= 1'b0;
            coin_reject_q <= 1'b0;
            sold_out_q    <= 1'b0;
            need_more_q   <= 1'b0;
            busy_q        <= 1'b0;
            for (int i = 0; i < N_ITEMS; i++) begin
                stock_q[i] <= C_STOCK_INIT;
            end
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            vend_item_q   <= vend_item_d;
            vend_valid_q  <= vend_valid_d;
            change_q      <= change_d;
            coin_reject_q <= coin_reject_d;
            sold_out_q    <= sold_out_d;
            need_more_q   <= need_more_d;
            busy_q        <= busy_d;
            for (int i = 0; i < N_ITEMS; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

    assign vend_valid_o  = vend_valid_q;
    assign vend_item_o   = vend_item_q;
    assign change_o      = change_q;
    assign credit_o      = credit_q;
    assign coin_reject_o = coin_reject_q;
    assign sold_out_o    = sold_out_q;
    assign need_more_o   = need_more_q;
    assign busy_o        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_vending_controller_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_vending_controller_multi
// Purpose  : Self-checking bench for vending_controller_multi with prices
//            {3,5,2,7}. A transaction-level model tracks credit, stock and
//            the current activity; a compare process checks every output on
//            each falling edge, and directed scenarios add literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vending_controller_multi;

    localparam int N_ITEMS  = 4;
    localparam int SEL_W    = 2;
    localparam int COIN_W   = 2;
    localparam int CREDIT_W = 4;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        coin_valid, sel_valid, cancel, refill, vend_ready;
    logic [COIN_W-1:0]           coin_val;
    logic [SEL_W-1:0]            sel_item, refill_item;
    logic [N_ITEMS*CREDIT_W-1:0] price_table;
    logic                        vend_valid, change, coin_reject, sold_out, need_more, busy;
    logic [SEL_W-1:0]            vend_item;
    logic [CREDIT_W-1:0]         credit;

    always #5 clk = ~clk;

    vending_controller_multi dut (
        .clk_i         (clk),
        .reset_i       (rst),
        .coin_valid_i  (coin_valid),
        .coin_val_i    (coin_val),
        .sel_valid_i   (sel_valid),
        .sel_item_i    (sel_item),
        .cancel_i      (cancel),
        .price_table_i (price_table),
        .refill_i      (refill),
        .refill_item_i (refill_item),
        .vend_ready_i  (vend_ready),
        .vend_valid_o  (vend_valid),
        .vend_item_o   (vend_item),
        .change_o      (change),
        .credit_o      (credit),
        .coin_reject_o (coin_reject),
        .sold_out_o    (sold_out),
        .need_more_o   (need_more),
        .busy_o        (busy)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: mode 0 = waiting for first coin, 1 = holding credit,
    // 2 = offering item, 3 = paying out units.
    // ------------------------------------------------------------------
    int price [N_ITEMS] = '{3, 5, 2, 7};
    int m_mode  = 0;
    int m_credit = 0;
    int m_item  = 0;
    int m_stock [N_ITEMS] = '{2, 2, 2, 2};
    int e_rej = 0, e_so = 0, e_nm = 0;

    always @(posedge clk or posedge rst) begin : model
        int mode, cr, it, rj, so, nm;
        int st [N_ITEMS];
        bit coin;
        if (rst) begin
            m_mode   <= 0;
            m_credit <= 0;
            m_item   <= 0;
            e_rej    <= 0;
            e_so     <= 0;
            e_nm     <= 0;
            m_stock  <= '{2, 2, 2, 2};
        end else begin
            mode = m_mode; cr = m_credit; it = m_item; st = m_stock;
            rj = 0; so = 0; nm = 0;
            coin = coin_valid && (coin_val != 0);
            if (mode <= 1) begin
                if (cancel) begin
                    rj = int'(coin);
                    if (cr > 0) mode = 3;
                end else if (sel_valid) begin
                    rj = int'(coin);
                    if (cr > 0) begin
                        if (int'(sel_item) >= N_ITEMS || st[sel_item] == 0) so = 1;
                        else if (cr < price[sel_item]) nm = 1;
                        else begin mode = 2; it = int'(sel_item); end
                    end
                end else if (coin) begin
                    if (cr + int'(coin_val) <= 9) begin cr = cr + int'(coin_val); mode = 1; end
                    else rj = 1;
                end
            end else if (mode == 2) begin
                rj = int'(coin);
                if (vend_ready) begin
                    st[it] = st[it] - 1;
                    cr = cr - price[it];
                    mode = (cr > 0) ? 3 : 0;
                end
            end else begin
                rj = int'(coin);
                cr = cr - 1;
                if (cr == 0) mode = 0;
            end
            if (refill && int'(refill_item) < N_ITEMS) st[refill_item] = 2;
            m_mode   <= mode;
            m_credit <= cr;
            m_item   <= it;
            m_stock  <= st;
            e_rej    <= rj;
            e_so     <= so;
            e_nm     <= nm;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("vend_valid",  int'(vend_valid),  int'(m_mode == 2));
            chk("change",      int'(change),      int'(m_mode == 3));
            chk("busy",        int'(busy),        int'(m_mode >= 2));
            chk("credit",      int'(credit),      m_credit);
            chk("coin_reject", int'(coin_reject), e_rej);
            chk("sold_out",    int'(sold_out),    e_so);
            chk("need_more",   int'(need_more),   e_nm);
            if (m_mode == 2) chk("vend_item", int'(vend_item), m_item);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input int v);
        coin_valid = 1'b1; coin_val = COIN_W'(v);
        tick();
        coin_valid = 1'b0; coin_val = '0;
    endtask

    task automatic select(input int i);
        sel_valid = 1'b1; sel_item = SEL_W'(i);
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic handshake();
        vend_ready = 1'b1;
        tick();
        vend_ready = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        price_table = {4'd7, 4'd2, 4'd5, 4'd3};
        coin_valid = 0; coin_val = 0; sel_valid = 0; sel_item = 0; cancel = 0;
        refill = 0; refill_item = 0; vend_ready = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_credit", int'(credit), 0);
        chk("reset_vv",     int'(vend_valid), 0);
        chk("reset_busy",   int'(busy), 0);

        // Scenario 1: 2+2 credit, item0 (price 3), stall with a coin.
        put_coin(2); put_coin(2);
        chk("s1_credit4", int'(credit), 4);
        select(0);
        chk("s1_vv", int'(vend_valid), 1);
        chk("s1_item", int'(vend_item), 0);
        put_coin(1);
        chk("s1_vend_coin_rej", int'(coin_reject), 1);
        chk("s1_stall_credit", int'(credit), 4);
        tick();
        chk("s1_stall_vv", int'(vend_valid), 1);
        handshake();
        chk("s1_after_vv", int'(vend_valid), 0);
        chk("s1_change", int'(change), 1);
        chk("s1_credit1", int'(credit), 1);
        tick();
        chk("s1_done_change", int'(change), 0);
        chk("s1_done_credit", int'(credit), 0);

        // Scenario 2: credit 9, overflow coin, item3 (price 7) -> 2 change.
        put_coin(3); put_coin(3); put_coin(3);
        chk("s2_credit9", int'(credit), 9);
        put_coin(1);
        chk("s2_reject", int'(coin_reject), 1);
        chk("s2_credit_held", int'(credit), 9);
        select(3);
        chk("s2_item3", int'(vend_item), 3);
        handshake();
        chk("s2_credit2", int'(credit), 2);
        tick();
        chk("s2_credit1", int'(credit), 1);
        chk("s2_change1", int'(change), 1);
        tick();
        chk("s2_idle", int'(busy), 0);

        // Scenario 3: drain item2, sold_out, refill, vend again.
        for (int k = 0; k < 2; k++) begin
            put_coin(2); select(2); handshake();
            chk("s3_exact_change", int'(change), 0);
            chk("s3_exact_credit", int'(credit), 0);
        end
        put_coin(2); select(2);
        chk("s3_sold_out", int'(sold_out), 1);
        chk("s3_credit2", int'(credit), 2);
        refill = 1'b1; refill_item = 2'd2;
        tick();
        refill = 1'b0;
        select(2);
        chk("s3_refill_vv", int'(vend_valid), 1);
        handshake();

        // Scenario 4: need_more, cancel refund, cancel+sel+coin collision.
        put_coin(2); select(1);
        chk("s4_need_more", int'(need_more), 1);
        chk("s4_busy", int'(busy), 0);
        do_cancel();
        chk("s4_refund", int'(change), 1);
        tick(); tick();
        chk("s4_refund_done", int'(credit), 0);
        put_coin(2);
        cancel = 1'b1; sel_valid = 1'b1; sel_item = 2'd0; coin_valid = 1'b1; coin_val = 2'd1;
        tick();
        cancel = 1'b0; sel_valid = 1'b0; coin_valid = 1'b0; coin_val = '0;
        chk("s4_collision_rej", int'(coin_reject), 1);
        chk("s4_collision_change", int'(change), 1);
        tick(); tick();

        // Scenario 5: reset during change, then during a vend stall.
        put_coin(3); put_coin(3); select(0); handshake();
        chk("s5_pending3", int'(credit), 3);
        #2 rst = 1'b1;
        #1;
        chk("s5_rst_credit", int'(credit), 0);
        chk("s5_rst_change", int'(change), 0);
        chk("s5_rst_vv", int'(vend_valid), 0);
        tick();
        rst = 1'b0;
        put_coin(3); select(0);
        chk("s5_stock0_restored", int'(vend_valid), 1);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("s5_rst_vend_vv", int'(vend_valid), 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            put_coin(3); select(0);
            chk("s5_vend0", int'(vend_valid), 1);
            handshake();
        end
        put_coin(3); select(0);
        chk("s5_sold_out0", int'(sold_out), 1);
        do_cancel();
        repeat (3) tick();

        // Scenario 6: refill item1 on its vend handshake cycle.
        put_coin(3); put_coin(2); select(1);
        vend_ready = 1'b1; refill = 1'b1; refill_item = 2'd1;
        tick();
        vend_ready = 1'b0; refill = 1'b0;
        chk("s6_credit0", int'(credit), 0);
        for (int k = 0; k < 2; k++) begin
            put_coin(3); put_coin(2); select(1);
            chk("s6_vend1", int'(vend_valid), 1);
            handshake();
        end
        put_coin(3); put_coin(2); select(1);
        chk("s6_sold_out1", int'(sold_out), 1);
        do_cancel();
        repeat (6) tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
